// File: rtl/drfm_pkg.sv
// Shared types and defaults for the DRFM range delay path.
package drfm_pkg;

  localparam int DEPTH_DEFAULT  = 1024;
  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    REPLAY = 2'd2
  } state_t;

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port single-clock RAM, synchronous read, read-before-write on address collision.
module delay_ram #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/range_delay_buffer.sv
// Range delay line: dout = sample accepted `delay` valid samples earlier, 1 cycle after output_ready, no backpressure.
// Define RANGE_DELAY_STATS_EN to add the saturating replay_count output.
module range_delay_buffer
  import drfm_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                     M100CLK,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] sum,
  input  logic                     output_ready,
  input  logic [$clog2(DEPTH)-1:0] delay,
  input  logic                     delay_load,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  output logic                     filling,
  output logic                     delay_clamped
`ifdef RANGE_DELAY_STATS_EN
  ,
  output logic [31:0]              replay_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] ONE = AW'(1);

  state_t            state;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     fill_cnt;
  logic [AW-1:0]     dly;
  logic [DATA_W-1:0] dout_hold;
  logic [DATA_W-1:0] ram_q;
  logic [AW-1:0]     load_dly;
  logic [AW-1:0]     fill_next;
  logic [AW-1:0]     rd_addr;
  logic              rd_en;

  assign load_dly  = (delay == '0) ? ONE : delay;
  assign fill_next = fill_cnt + ONE;
  assign rd_addr   = wr_ptr - dly;
  // A reload takes priority over replay: the coincident sample starts the new fill.
  assign rd_en     = output_ready && (state == REPLAY) && !delay_load;

  delay_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (M100CLK),
    .we      (output_ready),
    .wr_addr (wr_ptr),
    .wr_data (sum),
    .re      (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  always_ff @(posedge M100CLK or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      fill_cnt      <= '0;
      dly           <= ONE;
      dout_valid    <= 1'b0;
      dout_hold     <= '0;
      delay_clamped <= 1'b0;
    end else begin
      dout_valid <= rd_en;
      if (dout_valid) dout_hold <= ram_q;
      if (output_ready) wr_ptr <= wr_ptr + ONE;
      if (delay_load) begin
        dly <= load_dly;
        if (delay == '0) delay_clamped <= 1'b1;
        if (output_ready) begin
          fill_cnt <= ONE;
          state    <= (load_dly == ONE) ? REPLAY : FILL;
        end else begin
          fill_cnt <= '0;
          state    <= FILL;
        end
      end else if (state == FILL && output_ready) begin
        fill_cnt <= fill_next;
        if (fill_next == dly) state <= REPLAY;
      end
    end
  end

  // RAM output is unreset, so the held copy supplies dout outside valid pulses.
  assign dout    = dout_valid ? ram_q : dout_hold;
  assign filling = (state == FILL);

`ifdef RANGE_DELAY_STATS_EN
  always_ff @(posedge M100CLK or posedge reset) begin
    if (reset) begin
      replay_count <= '0;
    end else if (delay_load) begin
      replay_count <= '0;
    end else if (dout_valid && replay_count != 32'hFFFF_FFFF) begin
      replay_count <= replay_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_range_delay_buffer.sv
// Scoreboard bench for range_delay_buffer: sample-count reference model, expected outputs queued per accepted sample.
module tb_range_delay_buffer;
  import drfm_pkg::*;

  localparam int DEPTH  = 1024;
  localparam int DATA_W = 32;
  localparam int AW     = 10;

  logic              M100CLK = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] sum = '0;
  logic              output_ready = 1'b0;
  logic [AW-1:0]     delay = '0;
  logic              delay_load = 1'b0;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              filling;
  logic              delay_clamped;
`ifdef RANGE_DELAY_STATS_EN
  logic [31:0]       replay_count;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] hist[$];
  state_t      mstate;
  int          mcnt;
  int          mdly;
  logic        mclamp;
  logic [31:0] mlast;
  longint      mrc;
  logic        mprev_v;
  logic [31:0] vseq;

  range_delay_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .M100CLK       (M100CLK),
    .reset         (reset),
    .sum           (sum),
    .output_ready  (output_ready),
    .delay         (delay),
    .delay_load    (delay_load),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .filling       (filling),
    .delay_clamped (delay_clamped)
`ifdef RANGE_DELAY_STATS_EN
    ,
    .replay_count  (replay_count)
`endif
  );

  always #5 M100CLK = ~M100CLK;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    hist.delete();
    mstate  = IDLE;
    mcnt    = 0;
    mdly    = 1;
    mclamp  = 1'b0;
    mlast   = '0;
    mrc     = 0;
    mprev_v = 1'b0;
  endtask

  task automatic observe();
    logic [31:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("dout_valid", dout_valid, 1);
      chk("dout", dout, e);
      mlast   = e;
      mprev_v = 1'b1;
    end else begin
      chk("dout_valid_low", dout_valid, 0);
      chk("dout_hold", dout, mlast);
      mprev_v = 1'b0;
    end
    chk("filling", filling, mstate == FILL);
    chk("delay_clamped", delay_clamped, mclamp);
`ifdef RANGE_DELAY_STATS_EN
    chk("replay_count", replay_count, mrc);
`endif
  endtask

  // Called just after a falling edge; drives one cycle and checks the result.
  task automatic step(input logic rdy, input logic [31:0] s, input logic ld, input int d);
    int ld_d;
    if (ld) mrc = 0;
    else if (mprev_v && mrc < 64'hFFFF_FFFF) mrc++;
    if (ld) begin
      ld_d = (d == 0) ? 1 : d;
      if (d == 0) mclamp = 1'b1;
      mdly   = ld_d;
      mcnt   = 0;
      mstate = FILL;
      if (rdy) begin
        mcnt = 1;
        if (mcnt == mdly) mstate = REPLAY;
      end
    end else if (rdy) begin
      if (mstate == REPLAY) exp_q.push_back(hist[hist.size() - mdly]);
      else if (mstate == FILL) begin
        mcnt++;
        if (mcnt == mdly) mstate = REPLAY;
      end
    end
    if (rdy) hist.push_back(s);
    output_ready = rdy;
    sum          = s;
    delay_load   = ld;
    delay        = d[AW-1:0];
    @(posedge M100CLK);
    @(negedge M100CLK);
    output_ready = 1'b0;
    delay_load   = 1'b0;
    observe();
  endtask

  task automatic run(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) step(1'b0, 32'd0, 1'b0, 0);
      step(1'b1, $urandom, 1'b0, 0);
    end
  endtask

  initial begin
    model_reset();
    @(negedge M100CLK);
    @(negedge M100CLK);
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_filling", filling, 0);
    chk("rst_clamped", delay_clamped, 0);
    reset = 1'b0;
    observe();

    // Samples before any load are stored but never replayed
    for (int i = 0; i < 5; i++) step(1'b1, 32'hA000_0000 + i, 1'b0, 0);

    // delay=4, sum=1..12 back to back
    step(1'b0, 32'd0, 1'b1, 4);
    for (int k = 1; k <= 12; k++) begin
      vseq = k;
      step(1'b1, vseq, 1'b0, 0);
    end

    // delay=8 replay, then reload to 3 on a coincident valid sample
    step(1'b0, 32'd0, 1'b1, 8);
    run(20, 1'b1);
    step(1'b1, 32'h0BAD_F00D, 1'b1, 3);
    run(15, 1'b1);

    // delay=0 clamps to a lag of one sample
    step(1'b0, 32'd0, 1'b1, 0);
    run(10, 1'b1);
    chk("clamp_sticky", delay_clamped, 1);

    // Maximum delay across several pointer wraps
    step(1'b0, 32'd0, 1'b1, 1023);
    run(3000, 1'b0);

    // 100 replayed samples, then a reload clears the count
    step(1'b0, 32'd0, 1'b1, 5);
    run(105, 1'b0);
    step(1'b0, 32'd0, 1'b0, 0);
`ifdef RANGE_DELAY_STATS_EN
    chk("replay_count_100", replay_count, 100);
`endif
    step(1'b0, 32'd0, 1'b1, 6);
`ifdef RANGE_DELAY_STATS_EN
    chk("replay_count_clr", replay_count, 0);
`endif
    run(10, 1'b0);

    // Reset asserted between edges while a valid pulse is showing
    chk("pre_rst_valid", dout_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_dout_valid", dout_valid, 0);
    chk("midrst_dout", dout, 0);
    chk("midrst_filling", filling, 0);
    chk("midrst_clamped", delay_clamped, 0);
    @(posedge M100CLK);
    @(negedge M100CLK);
    reset = 1'b0;
    model_reset();
    observe();
    run(8, 1'b1);
    step(1'b0, 32'd0, 1'b1, 2);
    run(12, 1'b1);
    step(1'b0, 32'd0, 1'b0, 0);
    step(1'b0, 32'd0, 1'b0, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
